// File: rtl/ppu_vram_arbiter_if.sv
// Bundle of render-fetch, CPU $2007 and VRAM signals around the PPU VRAM arbiter.
// slave = arbiter side; master = the surrounding PPU blocks and memory.
interface ppu_vram_arbiter_if;
    logic        render_req;
    logic [13:0] render_addr;
    logic        addr_load;
    logic [13:0] addr_data;
    logic        inc_32;
    logic        cpu_req;
    logic        cpu_we;
    logic [7:0]  cpu_wdata;
    logic [5:0]  pal_rdata;
    logic [7:0]  vram_rdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_busy;
    logic        overrun;
    logic [13:0] ptr;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_we;
    logic        cpu_grant;

    modport slave (
        input  render_req, render_addr, addr_load, addr_data, inc_32,
               cpu_req, cpu_we, cpu_wdata, pal_rdata, vram_rdata,
        output cpu_rdata, cpu_busy, overrun, ptr, vram_addr, vram_wdata,
               vram_we, cpu_grant
    );

    modport master (
        output render_req, render_addr, addr_load, addr_data, inc_32,
               cpu_req, cpu_we, cpu_wdata, pal_rdata, vram_rdata,
        input  cpu_rdata, cpu_busy, overrun, ptr, vram_addr, vram_wdata,
               vram_we, cpu_grant
    );
endinterface

// File: rtl/ppu_vram_arbiter.sv
// Shares the VRAM port between render fetch and CPU $2007 accesses; owns the VRAM pointer and read buffer.
// Latency: write issues 2 cycles after cpu_req, read buffer refreshed after 4; each render_req cycle in PEND adds one.
// Backpressure: none to the CPU; a cpu_req while busy is dropped and sets sticky overrun. Option: PPU_ARB_PAL_BYPASS_EN.
module ppu_vram_arbiter (
    input  logic               clock,
    input  logic               reset,
    ppu_vram_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PEND   = 2'd1,
        ACCESS = 2'd2,
        FILL   = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op_we;
    logic [7:0]  op_wdata;
    logic [13:0] op_addr;
    logic [13:0] ptr_q;
    logic [7:0]  read_buf;
    logic        overrun_q;

    logic        accept;
    logic        cpu_grant;
    logic [13:0] ptr_inc;
    logic [13:0] fetch_addr;
    logic [7:0]  cpu_rdata;

    assign accept    = (state == IDLE) && bus.cpu_req;
    assign cpu_grant = (state == ACCESS);
    // 14-bit add wraps naturally at the top of the VRAM space
    assign ptr_inc   = ptr_q + (bus.inc_32 ? 14'd32 : 14'd1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.cpu_req)     state_nxt = PEND;
            PEND:    if (!bus.render_req) state_nxt = ACCESS;
            ACCESS:  state_nxt = op_we ? IDLE : FILL;
            FILL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_we     <= 1'b0;
            op_wdata  <= 8'h00;
            op_addr   <= 14'h0000;
            ptr_q     <= 14'h0000;
            read_buf  <= 8'h00;
            overrun_q <= 1'b0;
        end else begin
            if (accept) begin
                op_we    <= bus.cpu_we;
                op_wdata <= bus.cpu_wdata;
                op_addr  <= bus.addr_load ? bus.addr_data : ptr_q;
            end
            // a $2006 reload beats the post-increment on the same edge
            if (bus.addr_load) begin
                ptr_q <= bus.addr_data;
            end else if (state == ACCESS) begin
                ptr_q <= ptr_inc;
            end
            if (state == FILL) begin
                read_buf <= bus.vram_rdata;
            end
            if (bus.cpu_req && (state != IDLE)) begin
                overrun_q <= 1'b1;
            end
        end
    end

`ifdef PPU_ARB_PAL_BYPASS_EN
    // palette reads answer immediately; the buffer refills from the nametable mirror underneath
    always_comb begin
        fetch_addr = op_addr;
        if (!op_we && (op_addr >= 14'h3F00)) begin
            fetch_addr = op_addr - 14'h1000;
        end
        cpu_rdata = read_buf;
        if (ptr_q >= 14'h3F00) begin
            cpu_rdata = {2'b00, bus.pal_rdata};
        end
    end
`else
    logic unused_pal;
    assign unused_pal = ^bus.pal_rdata;

    always_comb begin
        fetch_addr = op_addr;
        cpu_rdata  = read_buf;
    end
`endif

    assign bus.cpu_grant  = cpu_grant;
    assign bus.vram_addr  = cpu_grant ? fetch_addr : bus.render_addr;
    assign bus.vram_we    = cpu_grant && op_we;
    assign bus.vram_wdata = cpu_grant ? op_wdata : 8'h00;
    assign bus.cpu_rdata  = cpu_rdata;
    assign bus.cpu_busy   = (state != IDLE);
    assign bus.overrun    = overrun_q;
    assign bus.ptr        = ptr_q;
endmodule

// File: tb/tb_ppu_vram_arbiter.sv
// Directed bench for ppu_vram_arbiter: VRAM accesses are scoreboarded through an expected-access queue.
module tb_ppu_vram_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;

    ppu_vram_arbiter_if bus ();

    ppu_vram_arbiter dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [7:0]  data;
    } acc_t;

    acc_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [7:0] mem [0:16383];

    // VRAM model: read data appears one cycle after the address
    always @(posedge clock) begin
        bus.vram_rdata <= mem[bus.vram_addr];
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk14(input string tag, input logic [13:0] obs, input logic [13:0] exp);
        check(tag, {2'b00, obs}, {2'b00, exp});
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        check(tag, {8'h00, obs}, {8'h00, exp});
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, {15'd0, obs}, {15'd0, exp});
    endtask

    // Scoreboard: every granted cycle must match the oldest expected access
    always @(negedge clock) begin
        if (!reset) begin
            chk1("we_without_grant", bus.vram_we & ~bus.cpu_grant, 1'b0);
            if (bus.cpu_grant) begin
                if (exp_q.size() == 0) begin
                    chk1("grant_unexpected", bus.cpu_grant, 1'b0);
                end else begin
                    acc_t e;
                    e = exp_q.pop_front();
                    chk14("sb_addr", bus.vram_addr, e.addr);
                    chk1("sb_we", bus.vram_we, e.we);
                    if (e.we) chk8("sb_wdata", bus.vram_wdata, e.data);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
        bus.cpu_req   = 1'b0;
        bus.addr_load = 1'b0;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_ptr(input logic [13:0] v);
        bus.addr_load = 1'b1;
        bus.addr_data = v;
        cyc();
    endtask

    task automatic issue(input logic we, input logic [13:0] addr, input logic [7:0] data);
        acc_t e;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_wdata = data;
        e.we   = we;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'hEE;
        mem[14'h2400] = 8'h11;
        mem[14'h2401] = 8'h22;
        mem[14'h2F05] = 8'h77;
        mem[14'h3F05] = 8'h5C;

        bus.render_req  = 1'b0;
        bus.render_addr = 14'h1234;
        bus.addr_load   = 1'b0;
        bus.addr_data   = 14'h0000;
        bus.inc_32      = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.cpu_we      = 1'b0;
        bus.cpu_wdata   = 8'h00;
        bus.pal_rdata   = 6'h00;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        settle();
        chk1("rst_busy", bus.cpu_busy, 1'b0);
        chk1("rst_grant", bus.cpu_grant, 1'b0);
        chk1("rst_we", bus.vram_we, 1'b0);
        chk1("rst_overrun", bus.overrun, 1'b0);
        chk14("rst_ptr", bus.ptr, 14'h0000);
        chk8("rst_rdata", bus.cpu_rdata, 8'h00);
        chk14("rst_vaddr", bus.vram_addr, 14'h1234);
        chk8("rst_wdata", bus.vram_wdata, 8'h00);

        // Basic write with cycle-level timing
        load_ptr(14'h2000);
        chk14("ld_ptr", bus.ptr, 14'h2000);
        issue(1'b1, 14'h2000, 8'h5A);
        settle();
        chk1("wr_n_busy", bus.cpu_busy, 1'b0);
        cyc(); settle();
        chk1("wr_n1_busy", bus.cpu_busy, 1'b1);
        chk1("wr_n1_grant", bus.cpu_grant, 1'b0);
        cyc(); settle();
        chk1("wr_n2_grant", bus.cpu_grant, 1'b1);
        chk1("wr_n2_we", bus.vram_we, 1'b1);
        chk14("wr_n2_addr", bus.vram_addr, 14'h2000);
        chk8("wr_n2_data", bus.vram_wdata, 8'h5A);
        chk14("wr_n2_ptr", bus.ptr, 14'h2000);
        cyc(); settle();
        chk1("wr_n3_busy", bus.cpu_busy, 1'b0);
        chk1("wr_n3_we", bus.vram_we, 1'b0);
        chk14("wr_n3_ptr", bus.ptr, 14'h2001);

        // +32 wrap, with the pointer load in the request cycle
        bus.inc_32 = 1'b1;
        bus.addr_load = 1'b1;
        bus.addr_data = 14'h3FF0;
        issue(1'b1, 14'h3FF0, 8'hA5);
        cyc(); cyc(); cyc(); settle();
        chk14("inc32_wrap_ptr", bus.ptr, 14'h0010);
        bus.inc_32 = 1'b0;
        load_ptr(14'h3FFF);
        issue(1'b1, 14'h3FFF, 8'hC3);
        cyc(); cyc(); cyc(); settle();
        chk14("inc1_wrap_ptr", bus.ptr, 14'h0000);

        // Buffered reads
        load_ptr(14'h2400);
        issue(1'b0, 14'h2400, 8'h00);
        settle();
        chk8("rd1_old_buf", bus.cpu_rdata, 8'h00);
        cyc(); cyc(); settle();
        chk14("rd1_vaddr", bus.vram_addr, 14'h2400);
        chk1("rd1_no_we", bus.vram_we, 1'b0);
        cyc(); settle();
        chk1("rd1_fill_busy", bus.cpu_busy, 1'b1);
        cyc(); settle();
        chk1("rd1_done_busy", bus.cpu_busy, 1'b0);
        chk8("rd1_buf", bus.cpu_rdata, 8'h11);
        chk14("rd1_ptr", bus.ptr, 14'h2401);
        issue(1'b0, 14'h2401, 8'h00);
        settle();
        chk8("rd2_rdata", bus.cpu_rdata, 8'h11);
        cyc(); cyc(); cyc(); cyc(); settle();
        chk8("rd2_buf", bus.cpu_rdata, 8'h22);

        // Render holds the port for 5 cycles
        load_ptr(14'h2100);
        bus.render_req  = 1'b1;
        bus.render_addr = 14'h0AB0;
        issue(1'b1, 14'h2100, 8'h33);
        settle();
        chk14("rnd_track0", bus.vram_addr, 14'h0AB0);
        for (int k = 1; k < 5; k++) begin
            cyc();
            bus.render_addr = 14'h0AB0 + 14'(k);
            settle();
            chk14("rnd_track", bus.vram_addr, 14'h0AB0 + 14'(k));
            chk1("rnd_no_we", bus.vram_we, 1'b0);
            chk1("rnd_busy", bus.cpu_busy, 1'b1);
        end
        cyc();
        bus.render_req  = 1'b0;
        bus.render_addr = 14'h0AC0;
        settle();
        chk1("rnd_drop_grant", bus.cpu_grant, 1'b0);
        chk14("rnd_drop_addr", bus.vram_addr, 14'h0AC0);
        cyc(); settle();
        chk1("rnd_access_grant", bus.cpu_grant, 1'b1);
        chk1("rnd_access_we", bus.vram_we, 1'b1);
        bus.addr_load = 1'b1;
        bus.addr_data = 14'h1111;
        cyc(); settle();
        chk14("load_beats_inc", bus.ptr, 14'h1111);
        chk14("rnd_back_addr", bus.vram_addr, 14'h0AC0);

        // Request while busy is dropped
        load_ptr(14'h2200);
        chk1("ovr_before", bus.overrun, 1'b0);
        issue(1'b1, 14'h2200, 8'h44);
        cyc();
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_wdata = 8'h99;
        settle();
        chk1("ovr_same_cycle", bus.overrun, 1'b0);
        cyc(); settle();
        chk1("ovr_set", bus.overrun, 1'b1);
        cyc(); settle();
        chk1("ovr_done_busy", bus.cpu_busy, 1'b0);
        chk14("ovr_ptr", bus.ptr, 14'h2201);
        cyc(); settle();
        chk1("ovr_sticky", bus.overrun, 1'b1);

        // Palette region read
        load_ptr(14'h3F05);
        bus.pal_rdata = 6'h2A;
`ifdef PPU_ARB_PAL_BYPASS_EN
        issue(1'b0, 14'h2F05, 8'h00);
        settle();
        chk8("pal_immediate", bus.cpu_rdata, 8'h2A);
        cyc(); cyc(); cyc(); cyc(); settle();
        chk14("pal_ptr", bus.ptr, 14'h3F06);
        load_ptr(14'h2000);
        chk8("pal_refill", bus.cpu_rdata, 8'h77);
`else
        issue(1'b0, 14'h3F05, 8'h00);
        settle();
        chk8("pal_ignored", bus.cpu_rdata, 8'h22);
        cyc(); cyc(); cyc(); cyc(); settle();
        chk8("pal_buf", bus.cpu_rdata, 8'h5C);
`endif

        // Reset while an access is pending
        load_ptr(14'h2300);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_wdata = 8'h66;
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        settle();
        chk1("mid_rst_busy", bus.cpu_busy, 1'b0);
        chk1("mid_rst_overrun", bus.overrun, 1'b0);
        chk14("mid_rst_ptr", bus.ptr, 14'h0000);
        chk8("mid_rst_rdata", bus.cpu_rdata, 8'h00);
        cyc(); cyc(); cyc(); settle();
        chk1("mid_rst_no_we", bus.vram_we, 1'b0);

        check("queue_drained", 16'(exp_q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Shares the PPU's single VRAM port between the background/sprite fetch pipeline and CPU PPUDATA ($2007) accesses. Owns the CPU-visible VRAM pointer (loaded from the $2006 logic), sequences each CPU read/write into a free bus slot, applies the +1/+32 post-increment, and maintains the PPUDATA read buffer. Sits between the PPU register decode, the render fetch logic and the VRAM/CHR memory.

## Interface
- No parameters.
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- render_req  in  1  render fetch owns VRAM this cycle
- render_addr  in  14  render fetch address
- addr_load  in  1  load pointer (second $2006 write)
- addr_data  in  14  pointer load value
- inc_32  in  1  PPUCTRL[2]; post-increment 32 when 1, else 1
- cpu_req  in  1  one-cycle $2007 access strobe
- cpu_we  in  1  1 = write, 0 = read; qualified by cpu_req
- cpu_wdata  in  8  write data
- pal_rdata  in  6  palette RAM data at ptr[4:0] (used only with macro)
- vram_rdata  in  8  VRAM read data, valid one cycle after address
- cpu_rdata  out  8  value the CPU sees on a $2007 read
- cpu_busy  out  1  an accepted access is not yet complete
- overrun  out  1  sticky: cpu_req dropped while busy
- ptr  out  14  current VRAM pointer
- vram_addr  out  14  VRAM address
- vram_wdata  out  8  VRAM write data
- vram_we  out  1  VRAM write strobe
- cpu_grant  out  1  CPU owns VRAM port this cycle

## Operation
- States: IDLE, PEND, ACCESS, FILL.
- IDLE: cpu_req -> PEND; latch op_we, op_wdata, op_addr = ptr (or addr_data if addr_load same cycle).
- PEND: render_req=1 -> stay; render_req=0 -> ACCESS.
- ACCESS: cpu_grant=1, vram_addr=op_addr, vram_we=op_we, vram_wdata=op_wdata. ptr += inc_32 ? 32 : 1 at exiting edge. Write -> IDLE; read -> FILL.
- FILL: read_buf <= vram_rdata at exiting edge -> IDLE. vram port returns to render path.
- Port mux: cpu_grant=0 -> vram_addr=render_addr, vram_we=0.
- ACCESS is entered only from PEND with render_req=0 sampled the previous cycle; render fetch guarantees render_req stays low the following cycle (fetch slots are ≥2 cycles apart).
- cpu_rdata = read_buf (old buffer value; CPU samples it in its cpu_req cycle).
- cpu_busy = state != IDLE. cpu_req while busy: dropped, overrun <= 1 until reset.
- ptr: 14-bit, wraps 0x3FFF -> 0x0000 (+1) and 0x3FE0..0x3FFF -> low wrap (+32, mod 2^14).
- addr_load: ptr <= addr_data; wins over a same-edge increment. Does not alter a latched op_addr.

## Timing
- Reset: state=IDLE, ptr=0, read_buf=0, overrun=0; cpu_rdata=0, cpu_busy=0, cpu_grant=0, vram_we=0, vram_addr=render_addr, vram_wdata=0.
- Reset mid-operation aborts; no write is issued after reset asserts.
- cpu_req at edge N, render idle: PEND in N+1, ACCESS in N+2, ptr updated at edge N+3. Write: busy low from N+3. Read: FILL in N+3, read_buf valid and busy low from N+4.
- Each cycle render_req=1 while in PEND adds one cycle of latency; no starvation bound beyond render_req.
- vram_we is single-cycle, only in ACCESS.

## Configuration
- PPU_ARB_PAL_BYPASS_EN defined: when ptr ≥ 0x3F00, cpu_rdata = {2'b00, pal_rdata} (immediate, no buffer delay); the access still proceeds and refills read_buf from vram at op_addr − 0x1000. Writes unaffected.
- Undefined: pal_rdata ignored; cpu_rdata always read_buf; reads fetch op_addr unchanged.

## Test plan
- Reset, load ptr=0x2000, write 0x5A with render_req=0 -> one-cycle vram_we at 0x2000 with data 0x5A in cycle N+2; ptr=0x2001.
- inc_32=1, ptr=0x3FF0, write -> ptr=0x0010 after access.
- Read 0x2400 holding 0x11 twice -> first cpu_rdata = prior buffer (0 after reset), second = 0x11.
- render_req held high 5 cycles after cpu_req -> vram_addr tracks render_addr, no vram_we; access issues cycle after render_req drops.
- cpu_req during busy -> second op dropped, overrun=1, VRAM sees only first write.
- Macro on, ptr=0x3F05, pal_rdata=0x2A -> cpu_rdata=0x2A in request cycle; buffer refilled from 0x2F05.
